// File: rtl/jtframe_dwnld_pkg.sv
// Shared types for the ioctl-to-SDRAM download sequencer.
package jtframe_dwnld_pkg;

  localparam logic [1:0] MASK_LO = 2'b10;
  localparam logic [1:0] MASK_HI = 2'b01;

  typedef struct packed {
    logic [1:0]  bank;
    logic [21:0] addr;
    logic [1:0]  mask;
    logic [7:0]  data;
  } prog_entry_t;

  typedef enum logic [1:0] {IDLE, WAIT, GAP} seq_state_t;

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small synchronous FIFO of decoded SDRAM byte writes; a full FIFO still
// accepts a push when a pop happens in the same cycle.
module jtframe_dwnld_fifo
  import jtframe_dwnld_pkg::*;
#(
  parameter int AW = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  prog_entry_t din,
  input  logic        pop,
  output prog_entry_t dout,
  output logic        full,
  output logic        empty
);
  localparam int DEPTH = 2**AW;

  prog_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // storage needs no reset: the pointers define what is valid
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

endmodule

// File: rtl/jtframe_dwnld_seq.sv
// ioctl download to SDRAM programming port: bank decode, byte buffering,
// single-byte write handshake and the busy/settle tail.
module jtframe_dwnld_seq
  import jtframe_dwnld_pkg::*;
#(
  parameter logic [24:0] BA1_START   = 25'h040000,
  parameter logic [24:0] BA2_START   = 25'h080000,
  parameter logic [24:0] BA3_START   = 25'h0C0000,
  parameter int          FIFO_AW     = 2,
  parameter logic [7:0]  POST_CYCLES = 8'd64
)(
  input  logic        clk_rom,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic        dwnld_busy,
  output logic        fifo_ovf
);
  prog_entry_t in_entry, head;
  seq_state_t  state, state_nxt;
  logic [22:0] off;
  logic [7:0]  tail_cnt;
  logic        push, pop, full, empty, drop;
  logic        dl_q, dl_rise, tail_go;

  // first match wins, highest bank first; offset wraps at 8 MB per bank
  always_comb begin
    in_entry = '0;
    off      = '0;
    if (ioctl_addr >= BA3_START) begin
      in_entry.bank = 2'd3;
      off = 23'(ioctl_addr - BA3_START);
    end else if (ioctl_addr >= BA2_START) begin
      in_entry.bank = 2'd2;
      off = 23'(ioctl_addr - BA2_START);
    end else if (ioctl_addr >= BA1_START) begin
      in_entry.bank = 2'd1;
      off = 23'(ioctl_addr - BA1_START);
    end else begin
      in_entry.bank = 2'd0;
      off = ioctl_addr[22:0];
    end
    in_entry.addr = off[22:1];
    in_entry.mask = off[0] ? MASK_HI : MASK_LO;
    in_entry.data = ioctl_data;
  end

  assign push = ioctl_wr && downloading;
  assign drop = push && full && !pop;

  jtframe_dwnld_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk_rom),
    .rst   (rst),
    .push  (push),
    .din   (in_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    if (prog_rdy) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_rom) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= 2'b11;
      prog_bank <= '0;
    end else if (pop) begin
      {prog_bank, prog_addr, prog_mask, prog_data} <= head;
      prog_we <= 1'b1;
    end else if (state == WAIT && prog_rdy) begin
      prog_we <= 1'b0;
    end
  end

  assign dl_rise = downloading && !dl_q;
  // counter sits loaded until everything has drained, then counts down
  assign tail_go = !downloading && empty && (state == IDLE);

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      dl_q       <= 1'b0;
      dwnld_busy <= 1'b0;
      fifo_ovf   <= 1'b0;
      tail_cnt   <= '0;
    end else begin
      dl_q     <= downloading;
      fifo_ovf <= (fifo_ovf && !dl_rise) || drop;
      if (downloading) dwnld_busy <= 1'b1;
      if (!tail_go) begin
        tail_cnt <= POST_CYCLES;
      end else if (dwnld_busy) begin
        if (tail_cnt <= 8'd1) dwnld_busy <= 1'b0;
        if (tail_cnt != 8'd0) tail_cnt <= tail_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_dwnld_seq.sv
// Self-checking bench for jtframe_dwnld_seq with an SDRAM acknowledge model.
module tb_jtframe_dwnld_seq;
  localparam int POST = 64;

  logic        clk_rom = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic        prog_rdy = 1'b0;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask, prog_bank;
  logic        prog_we, dwnld_busy, fifo_ovf;

  int checks = 0;
  int errors = 0;

  bit          rdy_en = 1'b1;
  int          rdy_dly = 0;
  int          wcnt = 0;
  bit          we_seen = 1'b0;
  logic [33:0] held = '0;
  logic [33:0] got[$];

  bit mon_busy = 1'b0;
  bit busy_dropped = 1'b0;

  jtframe_dwnld_seq dut (
    .clk_rom     (clk_rom),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_bank   (prog_bank),
    .prog_we     (prog_we),
    .prog_rdy    (prog_rdy),
    .dwnld_busy  (dwnld_busy),
    .fifo_ovf    (fifo_ovf)
  );

  always #5 clk_rom = ~clk_rom;

  // SDRAM side: acknowledge rdy_dly cycles after prog_we rises, log each write
  always @(negedge clk_rom) begin
    prog_rdy = 1'b0;
    if (!prog_we) begin
      wcnt    = 0;
      we_seen = 1'b0;
    end else begin
      if (!we_seen) begin
        held    = {prog_bank, prog_addr, prog_mask, prog_data};
        we_seen = 1'b1;
      end
      if (rdy_en && wcnt >= rdy_dly) begin
        checks++;
        if ({prog_bank, prog_addr, prog_mask, prog_data} !== held) begin
          errors++;
          $display("FAIL prog_stable: got %h, expected %h",
                   {prog_bank, prog_addr, prog_mask, prog_data}, held);
        end
        got.push_back(held);
        prog_rdy = 1'b1;
        wcnt     = 0;
      end else begin
        wcnt++;
      end
    end
  end

  always @(negedge clk_rom)
    if (mon_busy && !dwnld_busy) busy_dropped = 1'b1;

  // reference decode straight from the address map, plain arithmetic
  function automatic logic [33:0] ref_entry(input logic [24:0] a, input logic [7:0] d);
    int unsigned base, b, off;
    logic [21:0] w;
    logic [1:0]  m;
    if (a >= 25'h0C0000)      begin b = 3; base = 32'h0C0000; end
    else if (a >= 25'h080000) begin b = 2; base = 32'h080000; end
    else if (a >= 25'h040000) begin b = 1; base = 32'h040000; end
    else                      begin b = 0; base = 0; end
    off = (32'(a) - base) % 32'h800000;
    w   = 22'(off / 2);
    m   = (off % 2 == 1) ? 2'b01 : 2'b10;
    return {2'(b), w, m, d};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_rom);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_rom);
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_rom);
      if (got.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    tick(3);
    checks++;
    if ({prog_we, prog_addr, prog_data, prog_mask, prog_bank, dwnld_busy, fifo_ovf} !==
        {1'b0, 22'd0, 8'd0, 2'b11, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: we=%b addr=%h data=%h mask=%b bank=%d busy=%b ovf=%b, expected 0/0/0/11/0/0/0",
               prog_we, prog_addr, prog_data, prog_mask, prog_bank, dwnld_busy, fifo_ovf);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_ignored_strobe;
    bit saw_we = 1'b0, saw_busy = 1'b0;
    got.delete();
    downloading = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(25'(i * 3), 8'(8'h50 + i));
    for (int i = 0; i < 20; i++) begin
      if (prog_we) saw_we = 1'b1;
      if (dwnld_busy) saw_busy = 1'b1;
      tick(1);
    end
    checks++;
    if (saw_we || got.size() != 0) begin
      errors++;
      $display("FAIL ignored_we: saw_we=%b writes=%0d, expected 0/0", saw_we, got.size());
    end
    checks++;
    if (saw_busy) begin
      errors++;
      $display("FAIL ignored_busy: busy seen=%b, expected 0", saw_busy);
    end
  endtask

  task automatic test_bank_decode;
    bit ok;
    logic [33:0] exp_e[3];
    exp_e[0] = {2'd0, 22'd0, 2'b01, 8'hA1};
    exp_e[1] = {2'd1, 22'd2, 2'b10, 8'hB2};
    exp_e[2] = {2'd3, 22'd1, 2'b01, 8'hC3};
    got.delete();
    rdy_en = 1'b1; rdy_dly = 3;
    downloading = 1'b1;
    tick(1);
    checks++;
    if (dwnld_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_set: got %b, expected 1", dwnld_busy);
    end
    send_byte(25'h000001, 8'hA1);
    send_byte(25'h040004, 8'hB2);
    send_byte(25'h0C0003, 8'hC3);
    downloading = 1'b0;
    wait_writes(3, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL decode_timeout: writes=%0d, expected 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_e[i]) begin
        errors++;
        $display("FAIL decode_%0d: got %h, expected %h", i, got[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_random_bursts;
    bit ok;
    logic [33:0] exp_q[$];
    logic [24:0] a;
    logic [7:0]  d;
    int n;
    got.delete();
    rdy_en = 1'b1;
    downloading = 1'b1;
    tick(1);
    for (int b = 0; b < 8; b++) begin
      rdy_dly = $urandom_range(0, 3);
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0:       a = 25'($urandom_range(0, 32'h1FFFFFF));
          1:       a = 25'(32'h040000 + $urandom_range(0, 3) - 2);
          2:       a = 25'(32'h080000 + $urandom_range(0, 3) - 2);
          default: a = 25'(32'h0C0000 + $urandom_range(0, 3) - 2);
        endcase
        d = 8'($urandom);
        exp_q.push_back(ref_entry(a, d));
        send_byte(a, d);
        if (k % 2 == 1) tick($urandom_range(0, 3));
      end
      wait_writes(exp_q.size(), 300, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL random_timeout: burst %0d writes=%0d, expected %0d", b, got.size(), exp_q.size());
      end
    end
    downloading = 1'b0;
    tick(4);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d writes, expected %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_entry_%0d: got %h, expected %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (fifo_ovf !== 1'b0) begin
      errors++;
      $display("FAIL random_ovf: got %b, expected 0", fifo_ovf);
    end
  endtask

  task automatic test_overflow;
    bit ok;
    logic [33:0] exp_q[$];
    got.delete();
    rdy_en = 1'b0;
    downloading = 1'b1;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(ref_entry(25'(32'h080010 + 2 * i), 8'(8'h30 + i)));
      send_byte(25'(32'h080010 + 2 * i), 8'(8'h30 + i));
    end
    tick(2);
    checks++;
    if (fifo_ovf !== 1'b1 || got.size() != 0) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b writes=%0d, expected 1/0", fifo_ovf, got.size());
    end
    rdy_dly = 1;
    rdy_en  = 1'b1;
    wait_writes(5, 200, ok);
    tick(30);
    downloading = 1'b0;
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL ovf_count: got %0d writes, expected 5", got.size());
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ovf_entry_%0d: got %h, expected %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_busy_tail;
    int k;
    got.delete();
    rdy_en = 1'b1; rdy_dly = 0;
    downloading = 1'b1;
    tick(2);
    ioctl_addr = 25'h000020; ioctl_data = 8'h77; ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    downloading = 1'b0;
    checks++;
    if (prog_we !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: prog_we=%b one edge after strobe, expected 0", prog_we);
    end
    tick(1);
    checks++;
    if (prog_we !== 1'b1) begin
      errors++;
      $display("FAIL latency: prog_we=%b two edges after strobe, expected 1", prog_we);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!prog_we) break;
    end
    // one GAP cycle, then POST_CYCLES of tail from the IDLE return
    for (k = 1; k <= 200; k++) begin
      tick(1);
      if (!dwnld_busy) break;
    end
    checks++;
    if (k != 1 + POST) begin
      errors++;
      $display("FAIL busy_tail: busy fell %0d cycles after ack, expected %0d", k, 1 + POST);
    end
  endtask

  task automatic test_reset_mid_wait;
    bit saw_we = 1'b0;
    got.delete();
    rdy_en = 1'b0;
    downloading = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) send_byte(25'(32'h000100 + i), 8'(8'h90 + i));
    tick(3);
    checks++;
    if (prog_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: prog_we=%b, expected 1 while stalled", prog_we);
    end
    rst = 1'b1;
    downloading = 1'b0;
    tick(1);
    checks++;
    if ({prog_we, dwnld_busy, fifo_ovf} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid: we/busy/ovf=%b%b%b, expected 000", prog_we, dwnld_busy, fifo_ovf);
    end
    rst = 1'b0;
    rdy_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (prog_we) saw_we = 1'b1;
    end
    checks++;
    if (saw_we || got.size() != 0) begin
      errors++;
      $display("FAIL rst_discard: saw_we=%b writes=%0d, expected 0/0", saw_we, got.size());
    end
  endtask

  task automatic test_restart_tail;
    bit ok;
    int k;
    got.delete();
    rdy_en = 1'b0;
    downloading = 1'b1;
    tick(1);
    for (int i = 0; i < 6; i++) send_byte(25'(32'h0C1000 + i), 8'(8'hE0 + i));
    tick(1);
    rdy_dly = 0;
    rdy_en  = 1'b1;
    downloading = 1'b0;
    busy_dropped = 1'b0;
    mon_busy = 1'b1;
    wait_writes(5, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL restart_timeout: writes=%0d, expected 5", got.size());
    end
    tick(11);
    checks++;
    if (fifo_ovf !== 1'b1) begin
      errors++;
      $display("FAIL restart_ovf_sticky: got %b, expected 1", fifo_ovf);
    end
    downloading = 1'b1;
    tick(1);
    checks++;
    if (fifo_ovf !== 1'b0) begin
      errors++;
      $display("FAIL restart_ovf_clear: got %b, expected 0", fifo_ovf);
    end
    tick(100);
    mon_busy = 1'b0;
    checks++;
    if (busy_dropped) begin
      errors++;
      $display("FAIL restart_busy: busy deasserted=%b, expected 0", busy_dropped);
    end
    downloading = 1'b0;
    for (k = 0; k < 200; k++) begin
      tick(1);
      if (!dwnld_busy) break;
    end
    checks++;
    if (dwnld_busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_end: busy=%b after final tail, expected 0", dwnld_busy);
    end
  endtask

  initial begin
    test_reset();
    test_ignored_strobe();
    test_bank_decode();
    test_random_bursts();
    test_overflow();
    test_busy_tail();
    test_reset_mid_wait();
    test_restart_tail();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
